// File: rtl/rvh_noc_pkg.sv
// Shared NoC definitions: QoS/VC-id field widths plus local-port injection tier encoding.
package rvh_noc_pkg;

  localparam int QoS_Value_Width              = 4;
  localparam int VC_ID_NUM_MAX_W              = 3;
  localparam int LOCAL_INJECT_AGE_MAX_DEFAULT = 15;

  typedef enum logic [1:0] {
    TIER_AGED,
    TIER_RT,
    TIER_COMMON
  } inject_tier_e;

endpackage

// File: rtl/local_inject_credit_bank.sv
// Per-VC credit counters for the router local input port: one consume and one free per cycle,
// saturating on over-return with a sticky error flag.
module local_inject_credit_bank
  import rvh_noc_pkg::*;
#(
  parameter int VC_NUM   = 2,
  parameter int VC_DEPTH = 2,
  parameter int IDX_W    = 1,
  parameter int ID_W     = VC_ID_NUM_MAX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              consume_vld,
  input  logic [IDX_W-1:0]  consume_id,
  input  logic              free_vld,
  input  logic [ID_W-1:0]   free_id,
  output logic [VC_NUM-1:0] nonzero,
  output logic              err
);

  localparam int CNT_W = $clog2(VC_DEPTH + 1);

  logic [VC_NUM-1:0][CNT_W-1:0] cnt;
  logic [VC_NUM-1:0]            inc, dec, full;
  logic                         bad_id, ovf;

  always_comb begin
    inc    = '0;
    dec    = '0;
    full   = '0;
    nonzero = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      inc[v]     = free_vld && (int'(free_id) == v);
      dec[v]     = consume_vld && (int'(consume_id) == v);
      full[v]    = (cnt[v] == CNT_W'(VC_DEPTH));
      nonzero[v] = (cnt[v] != '0);
    end
    // A return that coincides with a consume on the same VC is always legal.
    ovf    = |(inc & ~dec & full);
    bad_id = free_vld && (int'(free_id) >= VC_NUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) cnt[v] <= CNT_W'(VC_DEPTH);
      err <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (inc[v] && !dec[v] && !full[v]) cnt[v] <= cnt[v] + 1'b1;
        else if (dec[v] && !inc[v])        cnt[v] <= cnt[v] - 1'b1;
      end
      if (ovf || bad_id) err <= 1'b1;
    end
  end

endmodule

// File: rtl/local_port_inject_scheduler.sv
// Shares the router local input port among N_REQ requesters with tiered round-robin
// arbitration and per-VC credits. Optional starvation aging via LOCAL_INJECT_AGING_EN.
// Handshake: req_rdy_o[i] is a same-cycle grant; a flit transfers when req_vld_i[i] && req_rdy_o[i],
// and flit_vld_o mirrors that transfer to the router in the same cycle.
module local_port_inject_scheduler
  import rvh_noc_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int VC_NUM    = 2,
  parameter int RT_VC_NUM = 1,
  parameter int VC_DEPTH  = 2,
  parameter int AGE_MAX   = LOCAL_INJECT_AGE_MAX_DEFAULT,
  localparam int VC_IDX_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int SRC_W    = $clog2(N_REQ)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [N_REQ-1:0]                        req_vld_i,
  input  logic [N_REQ-1:0][QoS_Value_Width-1:0]   req_qos_i,
  output logic [N_REQ-1:0]                        req_rdy_o,
  input  logic                                    tx_lcrd_v_i,
  input  logic [VC_ID_NUM_MAX_W-1:0]              tx_lcrd_id_i,
  output logic                                    flit_vld_o,
  output logic [SRC_W-1:0]                        flit_src_o,
  output logic [VC_IDX_W-1:0]                     flit_vc_id_o,
  output logic                                    credit_err_o
);

  localparam logic [VC_NUM-1:0] RT_MASK     = VC_NUM'((1 << RT_VC_NUM) - 1);
  localparam logic [VC_NUM-1:0] COMMON_MASK = ~RT_MASK;

  logic [VC_NUM-1:0]   vc_nonzero, class_mask, cand;
  logic [N_REQ-1:0]    is_rt, elig, aged, sel_mask;
  logic                avail_rt, avail_com, found, vc_found, gnt;
  logic [SRC_W-1:0]    rr_ptr, grant_idx;
  logic [VC_IDX_W-1:0] vc_pick;
  int                  rr_idx;
  inject_tier_e        sel_tier;

  always_comb begin
    is_rt     = '0;
    elig      = '0;
    avail_rt  = |(vc_nonzero & RT_MASK);
    avail_com = |(vc_nonzero & COMMON_MASK);
    for (int i = 0; i < N_REQ; i++) begin
      is_rt[i] = (RT_VC_NUM > 0) && (req_qos_i[i] == '1);
      elig[i]  = req_vld_i[i] && (is_rt[i] ? avail_rt : avail_com);
    end
  end

  // Pick the highest non-empty tier, then round-robin inside it from rr_ptr.
  always_comb begin
    if (|(elig & aged))       sel_tier = TIER_AGED;
    else if (|(elig & is_rt)) sel_tier = TIER_RT;
    else                      sel_tier = TIER_COMMON;
    case (sel_tier)
      TIER_AGED: sel_mask = elig & aged;
      TIER_RT:   sel_mask = elig & is_rt;
      default:   sel_mask = elig & ~is_rt;
    endcase
    found     = 1'b0;
    grant_idx = '0;
    rr_idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      rr_idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && sel_mask[rr_idx]) begin
        found     = 1'b1;
        grant_idx = SRC_W'(rr_idx);
      end
    end
  end

  always_comb begin
    class_mask = is_rt[grant_idx] ? RT_MASK : COMMON_MASK;
    cand       = vc_nonzero & class_mask;
    vc_found   = 1'b0;
    vc_pick    = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (!vc_found && cand[v]) begin
        vc_found = 1'b1;
        vc_pick  = VC_IDX_W'(v);
      end
    end
  end

  assign gnt          = found && !rst;
  assign req_rdy_o    = gnt ? (N_REQ'(1) << grant_idx) : '0;
  assign flit_vld_o   = gnt;
  assign flit_src_o   = gnt ? grant_idx : '0;
  assign flit_vc_id_o = gnt ? vc_pick : '0;

  always_ff @(posedge clk) begin
    if (rst)      rr_ptr <= '0;
    else if (gnt) rr_ptr <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
  end

`ifdef LOCAL_INJECT_AGING_EN
  localparam int AGE_W = $clog2(AGE_MAX + 1);

  logic [N_REQ-1:0][AGE_W-1:0] age;

  always_ff @(posedge clk) begin
    if (rst) begin
      age <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_vld_i[i] || req_rdy_o[i])                  age[i] <= '0;
        else if (elig[i] && (age[i] != AGE_W'(AGE_MAX)))    age[i] <= age[i] + 1'b1;
      end
    end
  end

  always_comb begin
    aged = '0;
    for (int i = 0; i < N_REQ; i++) aged[i] = (age[i] == AGE_W'(AGE_MAX));
  end
`else
  // Without aging, common requesters can starve under sustained RT load.
  logic unused_age_max;
  assign unused_age_max = AGE_MAX[0];
  assign aged           = '0;
`endif

  local_inject_credit_bank #(
    .VC_NUM   (VC_NUM),
    .VC_DEPTH (VC_DEPTH),
    .IDX_W    (VC_IDX_W),
    .ID_W     (VC_ID_NUM_MAX_W)
  ) u_credit_bank (
    .clk         (clk),
    .rst         (rst),
    .consume_vld (gnt),
    .consume_id  (vc_pick),
    .free_vld    (tx_lcrd_v_i),
    .free_id     (tx_lcrd_id_i),
    .nonzero     (vc_nonzero),
    .err         (credit_err_o)
  );

endmodule
